// File: rtl/coffee_display_sched.sv
// coffee_display_sched: picks the message for the 4-digit multiplexed display
// (idle / drink selection / rotating error) and drives the digit scan.
// Message changes are only taken at scan-frame boundaries.
module coffee_display_sched #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 200
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] S,
    input  logic       SR,
    input  logic       SP,
    input  logic       SN,
    input  logic       VL,
    output logic [3:0] MSG,
    output logic [1:0] DIG,
    output logic [3:0] DIG_EN,
    output logic       ERR_ANY
);

    // A zero-width counter is not legal, so each width has a floor of 1 bit.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SHOW_SEL, SHOW_ERR} state_t;

    // synchroniser stages
    logic [3:0] s_m, s_s;
    logic       sr_m, sr_s, sp_m, sp_s, sn_m, sn_s, vl_m, vl_s;

    logic [3:0]    e;
    logic          err_any;
    logic [PW-1:0] pre;
    logic [1:0]    dig;
    logic          tick, frame_end;

    state_t        state, state_n;
    logic [1:0]    cur, cur_n;
    logic [HW-1:0] hold, hold_n;
    logic [3:0]    msg, msg_n;
    logic [3:0]    sel_code;

    // Lowest active error index (0 if none; only used when e != 0).
    function automatic logic [1:0] lowest(input logic [3:0] ev);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (ev[i]) r = 2'(i);
        return r;
    endfunction

    // Next active index after c, wrapping; the fourth step lands on c itself
    // so a sole active error keeps being selected.
    function automatic logic [1:0] next_after(input logic [3:0] ev, input logic [1:0] c);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = c;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = c + 2'(k);
            if (!found && ev[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s_m  <= '0;  s_s  <= '0;
            sr_m <= 1'b0; sr_s <= 1'b0;
            sp_m <= 1'b0; sp_s <= 1'b0;
            sn_m <= 1'b0; sn_s <= 1'b0;
            vl_m <= 1'b0; vl_s <= 1'b0;
        end else begin
            s_m  <= S;    s_s  <= s_m;
            sr_m <= SR;   sr_s <= sr_m;
            sp_m <= SP;   sp_s <= sp_m;
            sn_m <= SN;   sn_s <= sn_m;
            vl_m <= VL;   vl_s <= vl_m;
        end
    end

    // ERDI: a drink is requested before the money is validated.
    assign e = {~vl_s & (|s_s), sn_s, sp_s, sr_s};

    // Registered error summary; pulses even for errors too short to display.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) err_any <= 1'b0;
        else       err_any <= |e;
    end

    assign tick      = (pre == PRE_LAST);
    assign frame_end = tick & (dig == 2'd3);

    // Digit-slot prescaler and digit scan counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre <= '0;
            dig <= 2'd0;
        end else if (tick) begin
            pre <= '0;
            dig <= dig + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Selection priority S0 > S1 > S2 > S3.
    always_comb begin
        sel_code = 4'd0;
        if      (s_s[0]) sel_code = 4'd1;
        else if (s_s[1]) sel_code = 4'd2;
        else if (s_s[2]) sel_code = 4'd3;
        else if (s_s[3]) sel_code = 4'd4;
    end

    // FSM registers: state, rotating error pointer, hold counter, message.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cur   <= 2'd0;
            hold  <= '0;
            msg   <= 4'd0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            hold  <= hold_n;
            msg   <= msg_n;
        end
    end

    // Next-state / message decision, only acted on at a frame boundary.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        hold_n  = hold;
        msg_n   = msg;
        if (frame_end) begin
            if (|e) begin
                state_n = SHOW_ERR;
                if (state != SHOW_ERR) begin
                    cur_n  = lowest(e);
                    hold_n = '0;
                end else if (!e[cur]) begin
                    cur_n  = next_after(e, cur);
                    hold_n = '0;
                end else if (hold == HOLD_LAST) begin
                    cur_n  = next_after(e, cur);
                    hold_n = '0;
                end else begin
                    hold_n = hold + HW'(1);
                end
                msg_n = 4'd5 + {2'b00, cur_n};
            end else if (|s_s) begin
                state_n = SHOW_SEL;
                msg_n   = sel_code;
            end else begin
                state_n = IDLE;
                msg_n   = 4'd0;
            end
        end
    end

    assign MSG     = msg;
    assign DIG     = dig;
    assign DIG_EN  = 4'b0001 << dig;
    assign ERR_ANY = err_any;

endmodule
